// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered frame store and its
// buffer_select users.
package fb_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        DRAW  = 2'd1,
        READY = 2'd2
    } fsc_state_t;

    localparam int         DEF_ADDR_W   = 19;
    localparam int         DEF_DATA_W   = 4;
    localparam int         DEF_NUM_PIX  = 307200;
    localparam logic [3:0] DEF_BG_COLOR = 4'd0;

    // Buffer index to one-hot select: 0 -> 01, 1 -> 10.
    function automatic logic [1:0] onehot2(input logic sel);
        logic [1:0] oh;
        if (sel) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/frame_swap_ctrl.sv
// Double-buffer controller: owns the shared frame_buffer bus, clears the back
// buffer each frame and swaps front/back on vsync once drawing is complete.
module frame_swap_ctrl
    import fb_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_PIX  = DEF_NUM_PIX,
    parameter logic [DATA_W-1:0] BG_COLOR = DATA_W'(DEF_BG_COLOR)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              frame_done,
    output logic              frame_start,
    output logic [1:0]        we,
    output logic [1:0]        re,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_In,
    output logic              front
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

    fsc_state_t        state_r;
    logic              front_r;
    logic              vs_d_r;
    logic              vs_pend_r;
    logic              rd_valid_r;
    logic              frame_start_r;
    logic [ADDR_W-1:0] clr_cnt_r;

    logic vs_rise_s;
    logic clr_slot_s;
    logic clr_last_s;
    logic wr_slot_s;
    logic swap_s;

    assign vs_rise_s  = vsync & ~vs_d_r;
    assign clr_slot_s = (state_r == CLEAR) & ~rd_req;
    assign clr_last_s = clr_slot_s & (clr_cnt_r == LAST_PIX);
    assign wr_slot_s  = (state_r == DRAW) & ~rd_req & wr_req;
    // A read launched last cycle must see the old front buffer, hence the rd_valid guard.
    assign swap_s     = (state_r == READY) & vs_pend_r & ~rd_req & ~rd_valid_r;

    assign front       = front_r;
    assign re          = onehot2(front_r);
    assign rd_valid    = rd_valid_r;
    assign frame_start = frame_start_r;

    // Per-cycle bus arbitration: read, then clear, then drawer write, else idle.
    always_comb begin
        we      = 2'b00;
        address = {ADDR_W{1'b0}};
        data_In = {DATA_W{1'b0}};
        wr_ack  = 1'b0;
        if (!Reset_n) begin
            we = 2'b00;
        end else if (rd_req) begin
            address = rd_addr;
        end else if (state_r == CLEAR) begin
            address = clr_cnt_r;
            data_In = BG_COLOR;
            we      = onehot2(~front_r);
        end else if (wr_slot_s) begin
            address = wr_addr;
            data_In = wr_data;
            we      = onehot2(~front_r);
            wr_ack  = 1'b1;
        end else begin
            we = 2'b00;
        end
    end

    // Read-valid pipeline, vsync edge delay and the frame_start pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_d_r        <= 1'b0;
            rd_valid_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            vs_d_r        <= vsync;
            rd_valid_r    <= rd_req;
            frame_start_r <= clr_last_s;
        end
    end

    // Frame sequencing: clear the back buffer, draw, wait for vsync, swap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= CLEAR;
            front_r   <= 1'b0;
            vs_pend_r <= 1'b0;
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                CLEAR: begin
                    if (clr_last_s) begin
                        state_r <= DRAW;
                    end else if (clr_slot_s) begin
                        clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        clr_cnt_r <= clr_cnt_r;
                    end
                end
                DRAW: begin
                    if (frame_done) begin
                        state_r <= READY;
                    end else begin
                        state_r <= DRAW;
                    end
                end
                READY: begin
                    if (swap_s) begin
                        front_r   <= ~front_r;
                        vs_pend_r <= 1'b0;
                        clr_cnt_r <= {ADDR_W{1'b0}};
                        state_r   <= CLEAR;
                    end else if (vs_rise_s) begin
                        vs_pend_r <= 1'b1;
                    end else begin
                        vs_pend_r <= vs_pend_r;
                    end
                end
                default: begin
                    state_r   <= CLEAR;
                    clr_cnt_r <= {ADDR_W{1'b0}};
                    vs_pend_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Self-checking bench for frame_swap_ctrl with a 16-pixel frame: a frame-level
// model predicts the bus each cycle, directed scenarios pin literal timings.
module tb_frame_swap_ctrl;

    localparam int         AW   = 5;
    localparam int         DW   = 4;
    localparam int         NPIX = 16;
    localparam logic [3:0] BG   = 4'd0;

    logic          clk;
    logic          rst_n;
    logic          vsync, rd_req, wr_req, frame_done;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid, wr_ack, frame_start, front;
    logic [1:0]    we, re;
    logic [AW-1:0] address;
    logic [DW-1:0] data_In;

    int checks = 0;
    int errors = 0;

    frame_swap_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIX(NPIX), .BG_COLOR(BG)) dut (
        .Clk(clk), .Reset_n(rst_n), .vsync(vsync), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .frame_done(frame_done), .frame_start(frame_start),
        .we(we), .re(re), .address(address), .data_In(data_In), .front(front)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two frame_buffers as seen through buffer_select, written from the DUT bus.
    logic [DW-1:0] fb [0:1][0:31];
    bit fb_init;
    always @(posedge clk) begin
        if (!fb_init) begin
            for (int i = 0; i < 32; i++) begin
                fb[0][i] <= 4'hF;
                fb[1][i] <= 4'hF;
            end
            fb_init <= 1'b1;
        end else begin
            if (we[0]) fb[0][address] <= data_In;
            if (we[1]) fb[1][address] <= data_In;
        end
    end

    // Frame-level model: phase 0 clearing, 1 drawing, 2 waiting for vsync.
    int            m_phase, m_next;
    bit            m_front, m_pend, m_prev_rd, m_prev_vs, m_fs, m_init;
    logic [DW-1:0] mmem [0:1][0:31];
    always @(posedge clk or negedge rst_n) begin
        if (!m_init) begin
            for (int i = 0; i < 32; i++) begin
                mmem[0][i] = 4'hF;
                mmem[1][i] = 4'hF;
            end
            m_init = 1'b1;
        end
        if (!rst_n) begin
            m_phase = 0; m_next = 0; m_front = 0; m_pend = 0;
            m_prev_rd = 0; m_prev_vs = 0; m_fs = 0;
        end else begin
            m_fs = 0;
            case (m_phase)
                0: if (!rd_req) begin
                    mmem[1 - int'(m_front)][m_next] = BG;
                    if (m_next == NPIX - 1) begin m_phase = 1; m_fs = 1; end
                    else m_next = m_next + 1;
                end
                1: begin
                    if (!rd_req && wr_req) mmem[1 - int'(m_front)][wr_addr] = wr_data;
                    if (frame_done) m_phase = 2;
                end
                2: if (m_pend && !rd_req && !m_prev_rd) begin
                    m_front = !m_front; m_pend = 0; m_next = 0; m_phase = 0;
                end else if (vsync && !m_prev_vs) m_pend = 1;
                default: m_phase = 0;
            endcase
            m_prev_rd = rd_req;
            m_prev_vs = vsync;
        end
    end

    // Per-cycle comparison against the model, plus frame_start bookkeeping.
    int cyc_n, fs_at, fs_count;
    always @(negedge clk) begin
        logic [1:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic          e_ack;
        e_we = 2'b00; e_addr = '0; e_data = '0; e_ack = 1'b0;
        if (rst_n) begin
            if (rd_req) e_addr = rd_addr;
            else if (m_phase == 0) begin
                e_addr = AW'(m_next); e_data = BG; e_we = m_front ? 2'b01 : 2'b10;
            end else if (m_phase == 1 && wr_req) begin
                e_addr = wr_addr; e_data = wr_data; e_we = m_front ? 2'b01 : 2'b10; e_ack = 1'b1;
            end
        end
        chk("we", 32'(we), 32'(e_we));
        chk("address", 32'(address), 32'(e_addr));
        chk("wr_ack", 32'(wr_ack), 32'(e_ack));
        if (e_we != 2'b00) chk("data_In", 32'(data_In), 32'(e_data));
        chk("rd_valid", 32'(rd_valid), 32'(m_prev_rd));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("front", 32'(front), 32'(m_front));
        chk("re", 32'(re), m_front ? 32'h2 : 32'h1);
        if (!rst_n) begin
            cyc_n = 0; fs_count = 0; fs_at = -1;
        end else begin
            if (frame_start) begin fs_at = cyc_n; fs_count++; end
            cyc_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rd_req = 0; wr_req = 0; frame_done = 0; vsync = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        rst_n = 0;
        step();
        @(negedge clk);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_re", 32'(re), 32'h1);
        chk("rst_front", 32'(front), 32'h0);
        chk("rst_addr", 32'(address), 32'h0);
        step();
        rst_n = 1;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("fs_timeout", 32'(n < 200), 32'h1);
    endtask

    task automatic count_bad(input int b, input logic [3:0] v, output int bad);
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (fb[b][i] !== v) bad++;
    endtask

    initial begin
        int bad;
        rst_n = 0;
        // Reset, full clear into buffer1, frame_start at cycle 16.
        do_reset();
        wait_fs();
        @(negedge clk); #1;
        chk("fs_cycle", 32'(fs_at), 32'd16);
        chk("fs_once", 32'(fs_count), 32'd1);
        count_bad(1, 4'h0, bad); chk("clear_buf1", 32'(bad), 32'h0);
        count_bad(0, 4'hF, bad); chk("buf0_untouched", 32'(bad), 32'h0);
        step();
        // Read beats a pending write.
        rd_req = 1; rd_addr = 5'd9; wr_req = 1; wr_addr = 5'd5; wr_data = 4'hA;
        @(negedge clk);
        chk("ack_blocked", 32'(wr_ack), 32'h0);
        step();
        rd_req = 0;
        @(negedge clk);
        chk("ack_granted", 32'(wr_ack), 32'h1);
        chk("we_back", 32'(we), 32'h2);
        step();
        wr_req = 0;
        chk("buf1_5", 32'(fb[1][5]), 32'hA);
        // frame_done then vsync rise: swap lands two cycles after the rise.
        frame_done = 1; step(); frame_done = 0;
        vsync = 1; step();
        chk("front_t1", 32'(front), 32'h0);
        step();
        chk("front_t2", 32'(front), 32'h1);
        chk("re_t2", 32'(re), 32'h2);
        @(negedge clk);
        chk("clear_buf0_we", 32'(we), 32'h1);
        vsync = 0;
        wait_fs();
        count_bad(0, 4'h0, bad); chk("clear_buf0", 32'(bad), 32'h0);
        chk("buf1_kept", 32'(fb[1][5]), 32'hA);

        // Clear interrupted by reads on cycles 3..5.
        do_reset();
        for (int c = 0; c < 26; c++) begin
            rd_req = (c >= 3 && c <= 5); rd_addr = 5'd7;
            @(negedge clk);
            if (c >= 3 && c <= 5) chk("stall_addr", 32'(address), 32'd7);
            if (c >= 4 && c <= 6) chk("stall_rv", 32'(rd_valid), 32'h1);
            if (c == 6) chk("resume_addr", 32'(address), 32'd3);
            step();
        end
        rd_req = 0;
        chk("fs_cycle_stall", 32'(fs_at), 32'd19);
        // vsync rise during DRAW is not latched.
        vsync = 1; step(); step();
        frame_done = 1; step(); frame_done = 0;
        repeat (5) step();
        chk("no_swap", 32'(front), 32'h0);
        vsync = 0; step();
        vsync = 1; step();
        chk("late_t1", 32'(front), 32'h0);
        step();
        chk("late_t2", 32'(front), 32'h1);
        vsync = 0;

        // Reads in READY hold off the swap until rd_req and rd_valid are low.
        do_reset();
        wait_fs();
        step();
        frame_done = 1; step(); frame_done = 0;
        vsync = 1; rd_req = 1; rd_addr = 5'd3;
        step(); step(); step();
        rd_req = 0;
        @(negedge clk);
        chk("tail_rv", 32'(rd_valid), 32'h1);
        chk("tail_front", 32'(front), 32'h0);
        step();
        chk("commit_front", 32'(front), 32'h0);
        step();
        chk("swapped_front", 32'(front), 32'h1);
        vsync = 0;
        wait_fs();
        step();

        bad = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 32; i++)
                if (fb[b][i] !== mmem[b][i]) bad++;
        chk("mem_model", 32'(bad), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
